// File: rtl/ip_codma_pkg.sv
// Shared types and size-code helpers for the CODMA write machine.
package ip_codma_pkg;

    localparam int unsigned SIZE_W      = 4;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BEAT_DATA_W = 64;
    localparam int unsigned BEAT_W      = 3;

    localparam logic [SIZE_W-1:0] SZ_2W = 4'd3;
    localparam logic [SIZE_W-1:0] SZ_6W = 4'd8;
    localparam logic [SIZE_W-1:0] SZ_8W = 4'd9;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ASK     = 2'd1,
        WR_GRANTED = 2'd2,
        WR_UNUSED  = 2'd3
    } write_state_t;

    // Number of 64-bit beats for a size code; zero marks an illegal code.
    function automatic logic [BEAT_W-1:0] size_to_beats(input logic [SIZE_W-1:0] size);
        logic [BEAT_W-1:0] beats;
        case (size)
            SZ_2W:   beats = BEAT_W'(1);
            SZ_6W:   beats = BEAT_W'(3);
            SZ_8W:   beats = BEAT_W'(4);
            default: beats = BEAT_W'(0);
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ip_codma_write_machine.sv
// Snapshots the CODMA data register and writes it to the memory bus as
// consecutive 64-bit beats, reporting done/busy/error to the DMA FSM.
module ip_codma_write_machine
    import ip_codma_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WORDS = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             need_write_i,
    input  logic [SIZE_W-1:0]                size_i,
    input  logic [ADDR_W-1:0]                addr_i,
    input  logic [MAX_WORDS-1:0][WORD_W-1:0] data_reg_i,
    input  logic                             stop_i,
    input  logic                             bus_grant_i,
    input  logic                             bus_wready_i,
    input  logic                             bus_error_i,
    output logic                             bus_req_o,
    output logic                             bus_write_o,
    output logic [SIZE_W-1:0]                bus_size_o,
    output logic [ADDR_W-1:0]                bus_addr_o,
    output logic [BEAT_DATA_W-1:0]           bus_wdata_o,
    output logic                             bus_wvalid_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             wr_error_o,
    output write_state_t                     wr_state_r,
    output write_state_t                     wr_state_next_s
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS);

    logic [SIZE_W-1:0]                size_q;
    logic [ADDR_W-1:0]                base_q;
    logic [MAX_WORDS-1:0][WORD_W-1:0] snap_q;
    logic [BEAT_W-1:0]                beat_r;
    logic [BEAT_W-1:0]                beat_next;
    logic                             latch_en;
    logic                             done_next;
    logic                             err_next;
    logic                             last_beat;
    logic                             req_next;
    logic                             wvalid_next;
    logic [SIZE_W-1:0]                size_sel;
    logic [IDX_W-1:0]                 lo_idx;
    logic [IDX_W-1:0]                 hi_idx;
    logic [ADDR_W-1:0]                addr_next;
    logic [BEAT_DATA_W-1:0]           wdata_next;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_state_r <= WR_IDLE;
        end else begin
            wr_state_r <= wr_state_next_s;
        end
    end

    // Next state: stop beats bus error, bus error beats normal progress
    always_comb begin
        wr_state_next_s = wr_state_r;
        beat_next       = beat_r;
        latch_en        = 1'b0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        last_beat       = (BEAT_W'(beat_r + 1'b1) == size_to_beats(size_q));
        if (stop_i) begin
            wr_state_next_s = WR_IDLE;
            beat_next       = '0;
        end else if (bus_error_i && (wr_state_r != WR_IDLE)) begin
            wr_state_next_s = WR_IDLE;
            beat_next       = '0;
            err_next        = 1'b1;
        end else begin
            case (wr_state_r)
                WR_IDLE: begin
                    if (need_write_i) begin
                        latch_en = 1'b1;
                        if (size_to_beats(size_i) != '0) begin
                            wr_state_next_s = WR_ASK;
                        end else begin
                            wr_state_next_s = WR_UNUSED;
                            err_next        = 1'b1;
                        end
                    end
                end
                WR_ASK: begin
                    if (bus_grant_i) begin
                        wr_state_next_s = WR_GRANTED;
                    end
                end
                WR_GRANTED: begin
                    if (bus_wready_i) begin
                        if (last_beat) begin
                            wr_state_next_s = WR_IDLE;
                            beat_next       = '0;
                            done_next       = 1'b1;
                        end else begin
                            beat_next = BEAT_W'(beat_r + 1'b1);
                        end
                    end
                end
                default: begin
                    wr_state_next_s = WR_IDLE;
                end
            endcase
        end
    end

    // Bus-side values for the coming cycle
    always_comb begin
        req_next    = (wr_state_next_s == WR_ASK) || (wr_state_next_s == WR_GRANTED);
        wvalid_next = (wr_state_next_s == WR_GRANTED);
        size_sel    = latch_en ? size_i : size_q;
        lo_idx      = {beat_next[IDX_W-2:0], 1'b0};
        hi_idx      = {beat_next[IDX_W-2:0], 1'b1};
        addr_next   = base_q + ADDR_W'({beat_next, 3'b000});
        wdata_next  = {snap_q[hi_idx], snap_q[lo_idx]};
    end

    // Snapshot, beat counter and registered outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            size_q       <= '0;
            base_q       <= '0;
            snap_q       <= '0;
            beat_r       <= '0;
            bus_req_o    <= 1'b0;
            bus_write_o  <= 1'b0;
            bus_size_o   <= '0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_wvalid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            wr_error_o   <= 1'b0;
        end else begin
            if (latch_en) begin
                size_q <= size_i;
                base_q <= addr_i;
                snap_q <= data_reg_i;
            end
            beat_r       <= beat_next;
            bus_req_o    <= req_next;
            bus_write_o  <= req_next;
            bus_size_o   <= req_next ? size_sel : '0;
            bus_wvalid_o <= wvalid_next;
            bus_addr_o   <= wvalid_next ? addr_next : '0;
            bus_wdata_o  <= wvalid_next ? wdata_next : '0;
            busy_o       <= (wr_state_next_s != WR_IDLE);
            done_o       <= done_next;
            wr_error_o   <= err_next;
        end
    end

endmodule

// File: tb/tb_ip_codma_write_machine.sv
// Self-checking bench for the CODMA write machine against a transaction-level model.
module tb_ip_codma_write_machine;
    import ip_codma_pkg::*;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              need_write_i;
    logic [3:0]        size_i;
    logic [31:0]       addr_i;
    logic [7:0][31:0]  data_reg_i;
    logic              stop_i;
    logic              bus_grant_i;
    logic              bus_wready_i;
    logic              bus_error_i;
    logic              bus_req_o;
    logic              bus_write_o;
    logic [3:0]        bus_size_o;
    logic [31:0]       bus_addr_o;
    logic [63:0]       bus_wdata_o;
    logic              bus_wvalid_o;
    logic              busy_o;
    logic              done_o;
    logic              wr_error_o;
    write_state_t      wr_state_r;
    write_state_t      wr_state_next_s;

    int n_checks = 0;
    int n_fail   = 0;

    ip_codma_write_machine #(.ADDR_W(32), .MAX_WORDS(8)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .need_write_i    (need_write_i),
        .size_i          (size_i),
        .addr_i          (addr_i),
        .data_reg_i      (data_reg_i),
        .stop_i          (stop_i),
        .bus_grant_i     (bus_grant_i),
        .bus_wready_i    (bus_wready_i),
        .bus_error_i     (bus_error_i),
        .bus_req_o       (bus_req_o),
        .bus_write_o     (bus_write_o),
        .bus_size_o      (bus_size_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_wvalid_o    (bus_wvalid_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .wr_error_o      (wr_error_o),
        .wr_state_r      (wr_state_r),
        .wr_state_next_s (wr_state_next_s)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Beats per size code, straight from the size table.
    function automatic int model_beats(input logic [3:0] s);
        if (s == 4'd3) return 1;
        if (s == 4'd8) return 3;
        if (s == 4'd9) return 4;
        return 0;
    endfunction

    function automatic logic [7:0][31:0] rand_words();
        logic [7:0][31:0] w;
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        return w;
    endfunction

    function automatic logic [3:0] rand_legal_size();
        int r;
        r = $urandom_range(0, 2);
        if (r == 0) return 4'd3;
        if (r == 1) return 4'd8;
        return 4'd9;
    endfunction

    // wr_mode: 0 = wready high, 1 = toggle 1,0,1,..., 2 = random
    task automatic do_transfer(input logic [3:0] size, input logic [31:0] base,
                               input logic [7:0][31:0] words, input int grant_dly,
                               input int wr_mode, input bit stop_last);
        logic [31:0] exp_addr[$];
        logic [63:0] exp_data[$];
        int n;
        int k;
        int cyc;
        bit rdy;
        n = model_beats(size);
        k = 0;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(base + 32'(8 * i));
            exp_data.push_back({words[2*i+1], words[2*i]});
        end
        need_write_i = 1'b1;
        size_i = size;
        addr_i = base;
        data_reg_i = words;
        #1;
        n_checks++;
        if (wr_state_next_s !== WR_ASK) begin
            n_fail++;
            $display("FAIL start_next_state: got %0d want %0d", wr_state_next_s, WR_ASK);
        end
        step();
        need_write_i = 1'b0;
        data_reg_i = rand_words();
        size_i = 4'($urandom);
        addr_i = $urandom;
        n_checks++;
        if ({bus_req_o, bus_write_o, bus_wvalid_o, busy_o, bus_size_o} !== {4'b1101, size}) begin
            n_fail++;
            $display("FAIL request_phase: req/write/wvalid/busy/size got %b%b%b%b/%0d want 1101/%0d",
                     bus_req_o, bus_write_o, bus_wvalid_o, busy_o, bus_size_o, size);
        end
        for (int g = 0; g < grant_dly; g++) begin
            step();
            n_checks++;
            if (bus_req_o !== 1'b1 || bus_wvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_grant: req=%b wvalid=%b want req=1 wvalid=0", bus_req_o, bus_wvalid_o);
            end
        end
        bus_grant_i = 1'b1;
        step();
        while (k < n && cyc < 200) begin
            if (wr_mode == 0) rdy = 1'b1;
            else if (wr_mode == 1) rdy = (cyc % 2 == 0);
            else rdy = ($urandom_range(0, 2) != 0);
            bus_wready_i = rdy;
            bus_grant_i = 1'($urandom);
            stop_i = stop_last && rdy && (k == n - 1);
            n_checks++;
            if (bus_wvalid_o !== 1'b1 || bus_addr_o !== exp_addr[k] ||
                bus_wdata_o !== exp_data[k] || done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL beat%0d: wvalid=%b addr=%h data=%h done=%b want 1 %h %h 0",
                         k, bus_wvalid_o, bus_addr_o, bus_wdata_o, done_o, exp_addr[k], exp_data[k]);
            end
            step();
            if (rdy) k++;
            cyc++;
        end
        bus_wready_i = 1'b0;
        bus_grant_i = 1'b0;
        stop_i = 1'b0;
        n_checks++;
        if (k < n) begin
            n_fail++;
            $display("FAIL beat_timeout: accepted %0d beats want %0d", k, n);
        end
        n_checks++;
        if ({done_o, bus_req_o, bus_wvalid_o, busy_o, wr_error_o} !== {!stop_last, 4'b0000}) begin
            n_fail++;
            $display("FAIL completion: done/req/wvalid/busy/err got %b%b%b%b%b want %b0000",
                     done_o, bus_req_o, bus_wvalid_o, busy_o, wr_error_o, !stop_last);
        end
        step();
        n_checks++;
        if (done_o !== 1'b0 || wr_state_r !== WR_IDLE) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b state=%0d want 0/IDLE", done_o, wr_state_r);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        need_write_i = 1'b0;
        size_i = '0;
        addr_i = '0;
        data_reg_i = '0;
        stop_i = 1'b0;
        bus_grant_i = 1'b0;
        bus_wready_i = 1'b0;
        bus_error_i = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus_req_o, bus_write_o, bus_wvalid_o, busy_o, done_o, wr_error_o,
             bus_size_o, bus_addr_o, bus_wdata_o} !== '0 || wr_state_r !== WR_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: outputs not zero or state=%0d", wr_state_r);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        n_checks++;
        if (busy_o !== 1'b0 || bus_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b req=%b want 0/0", busy_o, bus_req_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0][31:0] w;
        for (int i = 0; i < 8; i++) w[i] = 32'hA0 + 32'(i);
        do_transfer(4'd9, 32'h0000_1000, w, 2, 0, 1'b0);
    endtask

    task automatic test_wready_toggle();
        do_transfer(4'd8, 32'h0000_2040, rand_words(), 0, 1, 1'b0);
    endtask

    task automatic test_snapshot();
        do_transfer(4'd3, 32'h0000_3008, rand_words(), 1, 0, 1'b0);
    endtask

    task automatic test_addr_wrap();
        do_transfer(4'd9, 32'hFFFF_FFF0, rand_words(), 0, 2, 1'b0);
    endtask

    task automatic test_illegal_size();
        need_write_i = 1'b1;
        size_i = 4'd5;
        addr_i = 32'h0000_4000;
        data_reg_i = rand_words();
        #1;
        n_checks++;
        if (wr_state_next_s !== WR_UNUSED) begin
            n_fail++;
            $display("FAIL illegal_next_state: got %0d want %0d", wr_state_next_s, WR_UNUSED);
        end
        step();
        need_write_i = 1'b0;
        n_checks++;
        if ({wr_error_o, busy_o, bus_req_o, bus_wvalid_o} !== 4'b1100 || wr_state_r !== WR_UNUSED) begin
            n_fail++;
            $display("FAIL illegal_first: err/busy/req/wvalid got %b%b%b%b state=%0d want 1100/UNUSED",
                     wr_error_o, busy_o, bus_req_o, bus_wvalid_o, wr_state_r);
        end
        step();
        n_checks++;
        if ({wr_error_o, busy_o, bus_req_o, done_o} !== 4'b0000 || wr_state_r !== WR_IDLE) begin
            n_fail++;
            $display("FAIL illegal_second: err/busy/req/done got %b%b%b%b state=%0d want 0000/IDLE",
                     wr_error_o, busy_o, bus_req_o, done_o, wr_state_r);
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] base;
        base = 32'h0000_5000;
        need_write_i = 1'b1;
        size_i = 4'd9;
        addr_i = base;
        data_reg_i = rand_words();
        step();
        need_write_i = 1'b0;
        bus_grant_i = 1'b1;
        step();
        bus_wready_i = 1'b1;
        step();
        n_checks++;
        if (bus_wvalid_o !== 1'b1 || bus_addr_o !== base + 32'd8) begin
            n_fail++;
            $display("FAIL err_beat2_addr: wvalid=%b addr=%h want 1 %h", bus_wvalid_o, bus_addr_o, base + 32'd8);
        end
        bus_error_i = 1'b1;
        step();
        bus_error_i = 1'b0;
        bus_wready_i = 1'b0;
        bus_grant_i = 1'b0;
        n_checks++;
        if ({busy_o, wr_error_o, done_o, bus_req_o, bus_wvalid_o} !== 5'b01000) begin
            n_fail++;
            $display("FAIL bus_error_abort: busy/err/done/req/wvalid got %b%b%b%b%b want 01000",
                     busy_o, wr_error_o, done_o, bus_req_o, bus_wvalid_o);
        end
        step();
        n_checks++;
        if (wr_error_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_error_pulse: err=%b done=%b want 0/0", wr_error_o, done_o);
        end
        do_transfer(4'd3, 32'h0000_6000, rand_words(), 0, 0, 1'b0);
    endtask

    task automatic test_stop_last();
        do_transfer(4'd9, 32'h0000_7000, rand_words(), 1, 0, 1'b1);
        do_transfer(4'd8, 32'h0000_7100, rand_words(), 0, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 20; t++) begin
            do_transfer(rand_legal_size(), {$urandom, 3'b000} & 32'hFFFF_FFF8 | 32'($urandom) << 3,
                        rand_words(), $urandom_range(0, 3), 2, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        need_write_i = 1'b1;
        size_i = 4'd9;
        addr_i = 32'h0000_8008;
        data_reg_i = rand_words();
        step();
        need_write_i = 1'b0;
        bus_grant_i = 1'b1;
        step();
        #2;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if ({bus_req_o, bus_write_o, bus_wvalid_o, busy_o, done_o, wr_error_o,
             bus_size_o, bus_addr_o, bus_wdata_o} !== '0 || wr_state_r !== WR_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: req=%b wvalid=%b busy=%b addr=%h state=%0d want all zero",
                     bus_req_o, bus_wvalid_o, busy_o, bus_addr_o, wr_state_r);
        end
        bus_grant_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        do_transfer(4'd3, 32'h0000_9000, rand_words(), 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wready_toggle();
        test_snapshot();
        test_addr_wrap();
        test_illegal_size();
        test_bus_error();
        test_stop_last();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_codma_write_machine.md
Name: ip_codma_write_machine

Overview:
Downstream consumer of the CODMA read machine. When the DMA FSM signals a write, the block snapshots the 8x32-bit data register and requests the memory bus. Once granted, it drives the snapshot out as 64-bit write beats at consecutive addresses. It reports done, busy and error to the DMA FSM.

Parameters:
ADDR_W, 32, byte address width
MAX_WORDS, 8, depth of data register in 32-bit words (fixed; beats = words/2)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
need_write_i  in  1  start request from DMA FSM (level, sampled in WR_IDLE only)
size_i  in  4  transfer size code: 3=2 words, 8=6 words, 9=8 words
addr_i  in  ADDR_W  destination base address (8-byte aligned)
data_reg_i  in  8x32  data register from read machine
stop_i  in  1  abort, return to idle
bus_grant_i  in  1  arbiter grant
bus_wready_i  in  1  slave accepts current beat
bus_error_i  in  1  bus error
bus_req_o  out  1  bus request
bus_write_o  out  1  write qualifier (high with bus_req_o)
bus_size_o  out  4  latched size code
bus_addr_o  out  ADDR_W  current beat address
bus_wdata_o  out  64  current beat data
bus_wvalid_o  out  1  beat valid
busy_o  out  1  not in WR_IDLE
done_o  out  1  one-cycle pulse after last beat accepted
wr_error_o  out  1  one-cycle pulse on illegal size or bus error
wr_state_r  out  write_state_t  current state
wr_state_next_s  out  write_state_t  next state (combinational)

Behaviour:
- Reset: all outputs 0, bus_addr_o/bus_wdata_o 0, wr_state_r=WR_IDLE, beat counter 0, snapshot 0.
- States: WR_IDLE, WR_ASK, WR_GRANTED, WR_UNUSED. All outputs are registered.
- WR_IDLE: when need_write_i=1, latch size_i, addr_i and data_reg_i (full snapshot). A legal size goes to WR_ASK; an illegal size goes to WR_UNUSED. Later changes to data_reg_i do not affect the transfer.
- WR_ASK: bus_req_o=bus_write_o=1 and bus_size_o=latched size. When bus_grant_i=1, go to WR_GRANTED.
- WR_GRANTED: bus_wvalid_o=1, bus_wdata_o={snap[2k+1],snap[2k]}, bus_addr_o=base+8k, where k is the beat index.
  - A beat is accepted on a cycle with wvalid&wready. On acceptance k increments and the next beat is presented the following cycle. Data and address hold stable while wready=0.
  - Beat counts: 1, 3 or 4 for size 3, 8 or 9.
  - On acceptance of the last beat: next state WR_IDLE, done_o=1 for one cycle, bus_req_o/bus_wvalid_o drop.
- bus_grant_i dropping during WR_GRANTED is ignored; the arbiter keeps grant until req falls.
- Latency: need_write_i sampled at edge N gives bus_req_o high after edge N. Grant sampled at edge M gives wvalid high after edge M. With wready tied high, 4 beats complete in 4 cycles and done_o pulses in the cycle after the final acceptance edge.
- WR_UNUSED: wr_error_o=1 for one cycle, then WR_IDLE. No bus request is made.
- bus_error_i (any state except IDLE): go to WR_IDLE next edge, wr_error_o pulse, no done_o, counter cleared.
- stop_i: go to WR_IDLE next edge, no done_o, no error. stop_i has priority over bus_error_i, which has priority over normal transitions.
- need_write_i while busy is ignored; no queuing.
- Simultaneous last-beat acceptance and stop_i: stop wins and done_o is not asserted. The beat is still considered written on the bus.
- Address arithmetic: ADDR_W-bit modulo wrap; the base address is not checked for wrap.
- busy_o = (wr_state_r != WR_IDLE).

Decomposition:
- ip_codma_pkg holds write_state_t (WR_IDLE, WR_ASK, WR_GRANTED, WR_UNUSED) and size-code constants SZ_2W=3, SZ_6W=8, SZ_8W=9.
- The package also holds a function size_to_beats(size) returning 0 for an illegal code.
- No sub-module; FSM and datapath live in a single module.

Test Plan:
- size=9, addr=0x1000, data words 0..7 = 0xA0..0xA7, grant after 2 cycles, wready=1 -> 4 beats at 0x1000/08/10/18, first wdata=0x000000A1_000000A0, done_o one pulse.
- size=8 with wready toggling 1,0,1,0 -> 3 beats, wdata/addr stable while wready=0, done_o after 3rd acceptance.
- size=3, data_reg_i changed the cycle after start -> single beat carries the snapshot value, not the new one.
- size=5 -> WR_UNUSED, wr_error_o pulse, bus_req_o never asserted, back to idle in 2 cycles.
- bus_error_i during beat 2 of size 9 -> idle next cycle, wr_error_o pulse, no done_o. A fresh size=3 request then completes normally.
- stop_i coincident with last-beat acceptance -> no done_o. reset_n_i asserted mid-transfer -> all outputs 0 asynchronously.
